rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 13 +
 rtl/rst_seq_cnt.sv | 44 ++++
 rtl/rst_seq.sv | 100 ++++++++++
 tb/tb_rst_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and
// the width of the inter-stage delay counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/rst_seq_cnt.sv
// Clearable delay counter: counts while enabled, wraps to zero on the edge at
// which it sits at the terminal value, and flags that terminal value on tc_o.
module rst_seq_cnt
    import rst_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == term_i);

    // Next count: clear wins, otherwise count up and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            if (tc_o) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: holds all domains in reset, then releases them one
// by one from bit 0. Define RST_SEQ_SOFT_REQ_EN to allow SOFT_REQ re-sequencing.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_DLY   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SOFT_REQ,
    output logic                   SOFT_ACK,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
    output logic                   SEQ_DONE
);

    localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;
    localparam logic [CNT_W-1:0]       HOLD_TERM  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STAGE_TERM = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST  = NUM_DOMAINS'(1);
`ifdef RST_SEQ_SOFT_REQ_EN
    localparam logic SOFT_EN = 1'b1;
`else
    localparam logic SOFT_EN = 1'b0;
`endif

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_DOMAINS-1:0]  dom_q;
    logic                    done_q;
    logic                    ack_q;
    logic                    tc_s;
    logic                    soft_accept_s;
    logic [CNT_W-1:0]        term_s;

    assign soft_accept_s = SOFT_EN & SOFT_REQ & (state_q == ST_DONE);
    assign term_s        = (state_q == ST_HOLD) ? HOLD_TERM : STAGE_TERM;

    rst_seq_cnt u_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clear_i (soft_accept_s),
        .en_i    (state_q != ST_DONE),
        .term_i  (term_s),
        .tc_o    (tc_s)
    );

    // Sequencing FSM; dom_q is a thermometer code, so a shift-in of 1 releases
    // exactly the next domain and released bits can only drop via reset/soft restart.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_HOLD;
            idx_q   <= {IDX_W{1'b0}};
            dom_q   <= {NUM_DOMAINS{1'b0}};
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    if (tc_s) begin
                        dom_q   <= DOM_FIRST;
                        idx_q   <= {IDX_W{1'b0}};
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (tc_s) begin
                        if (idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            dom_q <= (dom_q << 1) | DOM_FIRST;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (soft_accept_s) begin
                        dom_q   <= {NUM_DOMAINS{1'b0}};
                        done_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        idx_q   <= {IDX_W{1'b0}};
                        state_q <= ST_HOLD;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign DOMAIN_RST_N = dom_q;
    assign SEQ_DONE     = done_q;
    assign SOFT_ACK     = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: three parameterisations checked against an edge-count
// model of the release schedule, plus directed edge-numbered checks.
module tb_rst_seq;

`ifdef RST_SEQ_SOFT_REQ_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       SOFT_REQ;
    logic [2:0] dom_a;
    logic [0:0] dom_b;
    logic [7:0] dom_c;
    logic       done_a, done_b, done_c;
    logic       ack_a, ack_b, ack_c;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int acks_a  = 0;

    int   e_m   [3];
    logic ack_m [3];
    logic [7:0] dom_obs [3];
    logic       done_obs[3];
    logic       ack_obs [3];

    always #5 CLK = ~CLK;

    rst_seq u_dut_a (
        .CLK(CLK), .RST(RST), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_a), .DOMAIN_RST_N(dom_a), .SEQ_DONE(done_a)
    );

    rst_seq #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGE_DLY(1)) u_dut_b (
        .CLK(CLK), .RST(RST), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_b), .DOMAIN_RST_N(dom_b), .SEQ_DONE(done_b)
    );

    rst_seq #(.NUM_DOMAINS(8), .HOLD_CYCLES(2), .STAGE_DLY(1)) u_dut_c (
        .CLK(CLK), .RST(RST), .SOFT_REQ(SOFT_REQ),
        .SOFT_ACK(ack_c), .DOMAIN_RST_N(dom_c), .SEQ_DONE(done_c)
    );

    always_comb begin
        dom_obs[0]  = {5'b00000, dom_a};
        dom_obs[1]  = {7'b0000000, dom_b};
        dom_obs[2]  = dom_c;
        done_obs[0] = done_a;
        done_obs[1] = done_b;
        done_obs[2] = done_c;
        ack_obs[0]  = ack_a;
        ack_obs[1]  = ack_b;
        ack_obs[2]  = ack_c;
    end

    function automatic int nd(int i);
        case (i)
            0:       return 3;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int hd(int i);
        case (i)
            0:       return 8;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int sd(int i);
        case (i)
            0:       return 16;
            1:       return 1;
            default: return 1;
        endcase
    endfunction

    // Domain k is out of reset once HOLD + k*STAGE edges have elapsed.
    function automatic logic [7:0] exp_dom(int i, int e);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < nd(i); k++) r[k] = (e >= hd(i) + k * sd(i));
        return r;
    endfunction

    function automatic logic exp_done(int i, int e);
        return (e >= hd(i) + nd(i) * sd(i));
    endfunction

    // Model: edges elapsed since the current sequence started.
    always @(posedge CLK or posedge RST) begin
        for (int i = 0; i < 3; i++) begin
            if (RST) begin
                e_m[i]   <= 0;
                ack_m[i] <= 1'b0;
            end else if (SOFT_EN && SOFT_REQ && exp_done(i, e_m[i])) begin
                e_m[i]   <= 0;
                ack_m[i] <= 1'b1;
            end else begin
                e_m[i]   <= (e_m[i] < 100000) ? e_m[i] + 1 : e_m[i];
                ack_m[i] <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("dom%0d", i), 32'(dom_obs[i]), 32'(exp_dom(i, e_m[i])));
            check_eq($sformatf("done%0d", i), 32'(done_obs[i]), 32'(exp_done(i, e_m[i])));
            check_eq($sformatf("ack%0d", i), 32'(ack_obs[i]), 32'(ack_m[i]));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        edge_n++;
        if (ack_a) acks_a++;
        check_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("rst_dom_a", 32'(dom_a), 32'd0);
        check_eq("rst_done_a", 32'(done_a), 32'd0);
        check_eq("rst_ack_a", 32'(ack_a), 32'd0);
        RST    = 1'b0;
        edge_n = 0;
        acks_a = 0;
    endtask

    // Fixed edge-numbered expectations for an undisturbed sequence.
    task automatic check_directed();
        case (edge_n)
            1:  begin
                    check_eq("b_dom@1", 32'(dom_b), 32'd1);
                    check_eq("b_done@1", 32'(done_b), 32'd0);
                end
            2:  begin
                    check_eq("b_done@2", 32'(done_b), 32'd1);
                    check_eq("c_dom@2", 32'(dom_c), 32'h01);
                end
            7:  check_eq("a_dom@7", 32'(dom_a), 32'd0);
            8:  check_eq("a_dom@8", 32'(dom_a), 32'd1);
            9:  begin
                    check_eq("c_dom@9", 32'(dom_c), 32'hff);
                    check_eq("c_done@9", 32'(done_c), 32'd0);
                end
            10: check_eq("c_done@10", 32'(done_c), 32'd1);
            23: check_eq("a_dom@23", 32'(dom_a), 32'd1);
            24: check_eq("a_dom@24", 32'(dom_a), 32'd3);
            39: check_eq("a_dom@39", 32'(dom_a), 32'd3);
            40: check_eq("a_dom@40", 32'(dom_a), 32'd7);
            55: check_eq("a_done@55", 32'(done_a), 32'd0);
            56: begin
                    check_eq("a_done@56", 32'(done_a), 32'd1);
                    check_eq("a_dom@56", 32'(dom_a), 32'd7);
                end
            default: ;
        endcase
    endtask

    initial begin
        RST      = 1'b1;
        SOFT_REQ = 1'b0;

        // Plain sequence after reset.
        do_reset();
        repeat (60) begin
            step();
            check_directed();
        end

        // Asynchronous reset in the middle of RELEASE, then a full restart.
        do_reset();
        while (edge_n < 30) step();
        #2 RST = 1'b1;
        #1;
        check_eq("async_dom_a", 32'(dom_a), 32'd0);
        check_eq("async_done_a", 32'(done_a), 32'd0);
        check_eq("async_dom_c", 32'(dom_c), 32'd0);
        @(negedge CLK);
        RST    = 1'b0;
        edge_n = 0;
        while (edge_n < 60) begin
            step();
            check_directed();
        end

        // Pulse ignored mid-sequence, pulse in DONE at edge 60.
        do_reset();
        while (edge_n < 70) begin
            SOFT_REQ = (edge_n == 19) || (edge_n == 59);
            step();
            if (edge_n <= 56) check_directed();
            if (edge_n == 60) begin
                check_eq("a_ack@60", 32'(ack_a), SOFT_EN ? 32'd1 : 32'd0);
                check_eq("a_dom@60", 32'(dom_a), SOFT_EN ? 32'd0 : 32'd7);
            end
            if (edge_n == 67) check_eq("a_dom@67", 32'(dom_a), SOFT_EN ? 32'd0 : 32'd7);
            if (edge_n == 68) check_eq("a_dom@68", 32'(dom_a), SOFT_EN ? 32'd1 : 32'd7);
        end
        SOFT_REQ = 1'b0;

        // Request held high from edge 20: exactly one ACK from the default instance.
        do_reset();
        while (edge_n < 100) begin
            SOFT_REQ = (edge_n >= 19);
            step();
        end
        check_eq("a_ack_count", 32'(acks_a), SOFT_EN ? 32'd1 : 32'd0);
        SOFT_REQ = 1'b0;

        // Random soft requests and occasional asynchronous resets.
        do_reset();
        repeat (800) begin
            SOFT_REQ = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 RST = 1'b1;
                #1 check_all();
                @(negedge CLK);
                RST = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
